// File: rtl/weave_shed_seq.sv
// Purpose : dobby-style shed sequencer. It replays a loaded lift table, one row per pick, with an optional twill rotation on each wrap.
// Latency : 1 cycle from the step sample edge to the shed/shed_valid update.
// Backpressure: none. Every step sampled in RUN (with ena=1 and no stop) produces exactly one pick.
// Ports: clk/rst_n (sync, active-low), ena (global hold), load_en/load_data (table fill),
//        start/stop/step (run control), twill_en (rotate per wrap); outputs shed/shed_valid,
//        pick_cnt, rows (rows loaded), state (0 IDLE, 1 LOAD, 2 RUN).
module weave_shed_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load_en,
    input  logic [7:0] load_data,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       twill_en,
    output logic [7:0] shed,
    output logic       shed_valid,
    output logic [7:0] pick_cnt,
    output logic [3:0] rows,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] table_q [8];
    logic [7:0] table_d [8];
    logic [3:0] rows_q, rows_d;
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] shift_q, shift_d;
    logic [7:0] shed_q, shed_d;
    logic       shed_valid_q, shed_valid_d;
    logic [7:0] pick_cnt_q, pick_cnt_d;
    logic [15:0] rot_tmp;
    logic       last_row;

    // A registered pulse is masked while ena is low, so a frozen core never shows a stale valid.
    assign shed       = shed_q;
    assign shed_valid = shed_valid_q & ena;
    assign pick_cnt   = pick_cnt_q;
    assign rows       = rows_q;
    assign state      = state_q;

    // Circular left rotation: shift the doubled pattern and keep the upper byte.
    assign rot_tmp  = {table_q[rd_ptr_q], table_q[rd_ptr_q]} << shift_q;
    assign last_row = ({1'b0, rd_ptr_q} == (rows_q - 4'd1));

    always_comb begin
        state_d      = state_q;
        table_d      = table_q;
        rows_d       = rows_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        shift_d      = shift_q;
        shed_d       = shed_q;
        shed_valid_d = 1'b0;
        pick_cnt_d   = pick_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    // A new load always discards the old row count and restarts at row 0.
                    table_d[0] = load_data;
                    rows_d     = 4'd1;
                    wr_ptr_d   = 3'd1;
                    state_d    = ST_LOAD;
                end else if (start && (rows_q != 4'd0)) begin
                    rd_ptr_d   = 3'd0;
                    shift_d    = 3'd0;
                    pick_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end
            end
            ST_LOAD: begin
                // The write is applied before start/stop, so a simultaneous row counts for RUN.
                if (load_en && (rows_q < 4'd8)) begin
                    table_d[wr_ptr_q] = load_data;
                    wr_ptr_d          = wr_ptr_q + 3'd1;
                    rows_d            = rows_q + 4'd1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    rd_ptr_d   = 3'd0;
                    shift_d    = 3'd0;
                    pick_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (step) begin
                    shed_d       = rot_tmp[15:8];
                    shed_valid_d = 1'b1;
                    pick_cnt_d   = pick_cnt_q + 8'd1;
                    if (last_row) begin
                        rd_ptr_d = 3'd0;
                        shift_d  = twill_en ? (shift_q + 3'd1) : 3'd0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rows_q       <= 4'd0;
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            shift_q      <= 3'd0;
            shed_q       <= 8'd0;
            shed_valid_q <= 1'b0;
            pick_cnt_q   <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                table_q[i] <= 8'd0;
            end
        end else if (ena) begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            shift_q      <= shift_d;
            shed_q       <= shed_d;
            shed_valid_q <= shed_valid_d;
            pick_cnt_q   <= pick_cnt_d;
            for (int i = 0; i < 8; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

endmodule

// File: tb/tb_weave_shed_seq.sv
// Purpose : directed self-checking bench for weave_shed_seq.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the stimulus is a fixed linear sequence.
module tb_weave_shed_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       load_en;
    logic [7:0] load_data;
    logic       start;
    logic       stop;
    logic       step;
    logic       twill_en;
    logic [7:0] shed;
    logic       shed_valid;
    logic [7:0] pick_cnt;
    logic [3:0] rows;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    weave_shed_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .load_en    (load_en),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .twill_en   (twill_en),
        .shed       (shed),
        .shed_valid (shed_valid),
        .pick_cnt   (pick_cnt),
        .rows       (rows),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_seq [4];

        rst_n = 1'b0; ena = 1'b1; load_en = 1'b0; load_data = 8'h00;
        start = 1'b0; stop = 1'b0; step = 1'b0; twill_en = 1'b0;
        tick(); tick();
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_shed", shed, 8'h00);
        chk("rst_valid", {7'd0, shed_valid}, 8'd0);
        chk("rst_pick", pick_cnt, 8'd0);
        chk("rst_rows", {4'd0, rows}, 8'd0);

        // Plain weave: rows 55, AA
        rst_n = 1'b1;
        load_en = 1'b1; load_data = 8'h55; tick();
        chk("pl_state_load", {6'd0, state}, 8'd1);
        chk("pl_rows1", {4'd0, rows}, 8'd1);
        load_data = 8'hAA; tick();
        chk("pl_rows2", {4'd0, rows}, 8'd2);
        load_en = 1'b0; start = 1'b1; tick();
        chk("pl_state_run", {6'd0, state}, 8'd2);
        chk("pl_pick0", pick_cnt, 8'd0);
        chk("pl_novalid", {7'd0, shed_valid}, 8'd0);
        start = 1'b0; step = 1'b1;
        exp_seq = '{8'h55, 8'hAA, 8'h55, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pl_shed", shed, exp_seq[i]);
            chk("pl_valid", {7'd0, shed_valid}, 8'd1);
            chk("pl_pick", pick_cnt, 8'(i + 1));
        end
        step = 1'b0; tick();
        chk("pl_valid_drop", {7'd0, shed_valid}, 8'd0);
        chk("pl_pick4", pick_cnt, 8'd4);
        chk("pl_shed_hold", shed, 8'hAA);

        // stop vs step in the same RUN cycle
        step = 1'b1; tick();
        chk("sv_pre_shed", shed, 8'h55);
        stop = 1'b1; tick();
        chk("sv_state", {6'd0, state}, 8'd0);
        chk("sv_valid", {7'd0, shed_valid}, 8'd0);
        chk("sv_shed", shed, 8'h55);
        chk("sv_pick", pick_cnt, 8'd5);
        stop = 1'b0; step = 1'b0; start = 1'b1; tick();
        chk("sv_restart_state", {6'd0, state}, 8'd2);
        chk("sv_restart_pick", pick_cnt, 8'd0);
        chk("sv_rows_kept", {4'd0, rows}, 8'd2);
        start = 1'b0; step = 1'b1; tick();
        chk("sv_row0", shed, 8'h55);
        chk("sv_pick1", pick_cnt, 8'd1);

        // ena low for 3 cycles with step held
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_valid", {7'd0, shed_valid}, 8'd0);
            chk("en_pick", pick_cnt, 8'd1);
        end
        ena = 1'b1; tick();
        chk("en_resume_shed", shed, 8'hAA);
        chk("en_resume_pick", pick_cnt, 8'd2);
        tick(); tick(); tick();
        chk("rr_pick5", pick_cnt, 8'd5);

        // Reset mid-RUN
        step = 1'b0; rst_n = 1'b0; tick();
        chk("rr_state", {6'd0, state}, 8'd0);
        chk("rr_pick", pick_cnt, 8'd0);
        chk("rr_rows", {4'd0, rows}, 8'd0);
        chk("rr_shed", shed, 8'h00);
        chk("rr_valid", {7'd0, shed_valid}, 8'd0);
        rst_n = 1'b1; start = 1'b1; tick();
        chk("rr_start_ignored", {6'd0, state}, 8'd0);
        start = 1'b0;

        // Twill: single row 03
        twill_en = 1'b1; load_en = 1'b1; load_data = 8'h03; tick();
        chk("tw_rows", {4'd0, rows}, 8'd1);
        load_en = 1'b0; start = 1'b1; tick();
        chk("tw_state", {6'd0, state}, 8'd2);
        start = 1'b0; step = 1'b1;
        exp_seq = '{8'h03, 8'h06, 8'h0C, 8'h18};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tw_shed", shed, exp_seq[i]);
        end
        step = 1'b0; stop = 1'b1; tick();
        chk("tw_stop", {6'd0, state}, 8'd0);
        stop = 1'b0; twill_en = 1'b0;

        // Overflow: 9 loads, the 9th must not land anywhere
        load_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            load_data = 8'(8'h10 + i);
            tick();
        end
        chk("ov_rows", {4'd0, rows}, 8'd8);
        chk("ov_state", {6'd0, state}, 8'd1);
        load_en = 1'b0; start = 1'b1; tick();
        start = 1'b0; step = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("ov_shed", shed, 8'(8'h10 + (i % 8)));
        end
        step = 1'b0; stop = 1'b1; tick();
        stop = 1'b0;

        // load_en + start together in LOAD; load/start ignored in RUN
        load_en = 1'b1; load_data = 8'hF0; tick();
        chk("ls_rows1", {4'd0, rows}, 8'd1);
        load_data = 8'h0F; start = 1'b1; tick();
        chk("ls_state", {6'd0, state}, 8'd2);
        chk("ls_rows2", {4'd0, rows}, 8'd2);
        load_data = 8'hEE; step = 1'b1; tick();
        chk("ls_shed0", shed, 8'hF0);
        chk("ls_run_rows", {4'd0, rows}, 8'd2);
        load_en = 1'b0; start = 1'b0; tick();
        chk("ls_shed1", shed, 8'h0F);
        tick();
        chk("ls_wrap", shed, 8'hF0);
        chk("ls_pick", pick_cnt, 8'd3);
        step = 1'b0; tick();
        chk("ls_end_valid", {7'd0, shed_valid}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
